// File: rtl/router_fifo_pkt.sv
// Packet-aware synchronous FIFO for router output channels with header tagging and a remaining-byte tracker.
// Optional sticky overflow/underflow flags are enabled by defining ROUTER_FIFO_PKT_ERR_EN.
module router_fifo_pkt #(
    parameter int  DATA_WIDTH   = 8,
    parameter int  DEPTH        = 16,
    parameter int  AFULL_THRESH = DEPTH - 2,
    localparam int ADDR_W       = $clog2(DEPTH)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  soft_reset,
    input  logic                  write_enb,
    input  logic                  read_enb,
    input  logic                  lfd_state,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic [ADDR_W:0]       level,
    output logic                  pkt_active
`ifdef ROUTER_FIFO_PKT_ERR_EN
    ,
    output logic                  err_ovf,
    output logic                  err_udf
`endif
);

    localparam logic [ADDR_W:0]       PTR_ONE = (ADDR_W + 1)'(1);
    localparam logic [DATA_WIDTH-2:0] PKT_ONE = (DATA_WIDTH - 1)'(1);
    localparam logic [ADDR_W:0]       AFULL_LVL = (ADDR_W + 1)'(AFULL_THRESH);

    logic [ADDR_W:0]       wr_ptr_reg;
    logic [ADDR_W:0]       rd_ptr_reg;
    logic [DATA_WIDTH:0]   mem_reg [DEPTH];
    logic                  lfd_reg;
    logic [DATA_WIDTH-2:0] pkt_count_reg;
    logic [DATA_WIDTH-2:0] pkt_count_next;
    logic [DATA_WIDTH-1:0] data_out_reg;
    logic [DATA_WIDTH-1:0] data_out_next;
    logic                  pkt_active_reg;

    logic                  wr_accept;
    logic                  rd_accept;
    logic [DATA_WIDTH:0]   rd_entry;
    logic [DEPTH-1:0]      wr_sel;

    // Flags come from pre-edge pointers, so full rejects the write and empty rejects the read.
    assign full        = (wr_ptr_reg == {~rd_ptr_reg[ADDR_W], rd_ptr_reg[ADDR_W-1:0]});
    assign empty       = (wr_ptr_reg == rd_ptr_reg);
    assign level       = wr_ptr_reg - rd_ptr_reg;
    assign almost_full = (level >= AFULL_LVL);

    assign wr_accept = write_enb && !full;
    assign rd_accept = read_enb && !empty;
    assign rd_entry  = mem_reg[rd_ptr_reg[ADDR_W-1:0]];

    assign data_out   = data_out_reg;
    assign pkt_active = pkt_active_reg;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
        assign wr_sel[gi] = wr_accept && (wr_ptr_reg[ADDR_W-1:0] == ADDR_W'(gi));
    end

    // Storage must be clearable in one cycle, so it is built from registers rather than RAM.
    always_ff @(posedge clock) begin
        if (reset || soft_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_sel[i]) begin
                    mem_reg[i] <= {lfd_reg, data_in};
                end
            end
        end
    end

    // A header loads length+1 (payload plus parity); the zero-extension keeps the add from overflowing.
    always_comb begin
        pkt_count_next = pkt_count_reg;
        data_out_next  = data_out_reg;
        if (rd_accept) begin
            data_out_next = rd_entry[DATA_WIDTH-1:0];
            if (rd_entry[DATA_WIDTH]) begin
                pkt_count_next = {1'b0, rd_entry[DATA_WIDTH-1:2]} + PKT_ONE;
            end else if (pkt_count_reg != '0) begin
                pkt_count_next = pkt_count_reg - PKT_ONE;
            end
        end else if (pkt_count_reg == '0) begin
            data_out_next = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            lfd_reg        <= 1'b0;
            pkt_count_reg  <= '0;
            data_out_reg   <= '0;
            pkt_active_reg <= 1'b0;
        end else if (soft_reset) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            lfd_reg        <= lfd_state;
            pkt_count_reg  <= '0;
            data_out_reg   <= '0;
            pkt_active_reg <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (rd_accept) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            lfd_reg        <= lfd_state;
            pkt_count_reg  <= pkt_count_next;
            data_out_reg   <= data_out_next;
            pkt_active_reg <= (pkt_count_next != '0);
        end
    end

`ifdef ROUTER_FIFO_PKT_ERR_EN
    logic err_ovf_reg;
    logic err_udf_reg;

    assign err_ovf = err_ovf_reg;
    assign err_udf = err_udf_reg;

    always_ff @(posedge clock) begin
        if (reset || soft_reset) begin
            err_ovf_reg <= 1'b0;
            err_udf_reg <= 1'b0;
        end else begin
            if (write_enb && full) begin
                err_ovf_reg <= 1'b1;
            end
            if (read_enb && empty) begin
                err_udf_reg <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_router_fifo_pkt.sv
// Randomized and directed bench for router_fifo_pkt, checked against a queue-based packet model.
module tb_router_fifo_pkt;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          soft_reset = 1'b0;
    logic          write_enb = 1'b0;
    logic          read_enb = 1'b0;
    logic          lfd_state = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic [AW:0]   level;
    logic          pkt_active;
`ifdef ROUTER_FIFO_PKT_ERR_EN
    logic          err_ovf;
    logic          err_udf;
`endif

    router_fifo_pkt #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clock       (clock),
        .reset       (reset),
        .soft_reset  (soft_reset),
        .write_enb   (write_enb),
        .read_enb    (read_enb),
        .lfd_state   (lfd_state),
        .data_in     (data_in),
        .data_out    (data_out),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .level       (level),
        .pkt_active  (pkt_active)
`ifdef ROUTER_FIFO_PKT_ERR_EN
        ,
        .err_ovf     (err_ovf),
        .err_udf     (err_udf)
`endif
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: a queue of {header, byte}, a remaining-byte count, and the expected output byte.
    logic [DW:0]   q[$];
    bit            lfd_m = 1'b0;
    int            pkt_m = 0;
    logic [DW-1:0] dout_m = '0;
    bit            ovf_m = 1'b0;
    bit            udf_m = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [DW:0] ent;
        bit f;
        bit e;
        if (reset) begin
            q.delete();
            lfd_m = 1'b0; pkt_m = 0; dout_m = '0; ovf_m = 1'b0; udf_m = 1'b0;
        end else if (soft_reset) begin
            q.delete();
            lfd_m = lfd_state; pkt_m = 0; dout_m = '0; ovf_m = 1'b0; udf_m = 1'b0;
        end else begin
            f = (q.size() == DEPTH);
            e = (q.size() == 0);
            if (write_enb && f) ovf_m = 1'b1;
            if (read_enb && e) udf_m = 1'b1;
            if (read_enb && !e) begin
                ent = q.pop_front();
                dout_m = ent[DW-1:0];
                if (ent[DW]) pkt_m = int'(ent[DW-1:2]) + 1;
                else if (pkt_m > 0) pkt_m = pkt_m - 1;
            end else if (pkt_m == 0) begin
                dout_m = '0;
            end
            if (write_enb && !f) q.push_back({lfd_m, data_in});
            lfd_m = lfd_state;
        end
    endtask

    // One clock: drive inputs, advance the model on the edge, compare every output 1 ns later.
    task automatic cyc(input bit we, input bit re, input bit lfd, input logic [DW-1:0] din,
                       input bit sr = 1'b0, input bit rst = 1'b0);
        write_enb = we; read_enb = re; lfd_state = lfd; data_in = din;
        soft_reset = sr; reset = rst;
        @(posedge clock);
        model_step();
        #1;
        check("level", 32'(level), 32'(q.size()));
        check("empty", 32'(empty), 32'(q.size() == 0));
        check("full", 32'(full), 32'(q.size() == DEPTH));
        check("almost_full", 32'(almost_full), 32'(q.size() >= DEPTH - 2));
        check("data_out", 32'(data_out), 32'(dout_m));
        check("pkt_active", 32'(pkt_active), 32'(pkt_m != 0));
`ifdef ROUTER_FIFO_PKT_ERR_EN
        check("err_ovf", 32'(err_ovf), 32'(ovf_m));
        check("err_udf", 32'(err_udf), 32'(udf_m));
`endif
        $display("[TB] t=%0t rst=%0b sr=%0b we=%0b re=%0b lfd=%0b din=%02h -> lvl=%0d dout=%02h act=%0b",
                 $time, rst, sr, we, re, lfd, din, level, data_out, pkt_active);
    endtask

    logic [DW-1:0] exp1 [5];
    bit            act1 [5];

    initial begin
        exp1[0] = 8'h0C; exp1[1] = 8'hA1; exp1[2] = 8'hA2; exp1[3] = 8'hA3; exp1[4] = 8'hA4;
        act1[0] = 1'b1;  act1[1] = 1'b1;  act1[2] = 1'b1;  act1[3] = 1'b1;  act1[4] = 1'b0;

        // Reset state
        cyc(1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_dout", 32'(data_out), 32'd0);

        // 1: one packet, header 0x0C (length 3) plus 4 bytes
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        cyc(1'b1, 1'b0, 1'b0, 8'h0C);
        for (int i = 1; i <= 4; i++) cyc(1'b1, 1'b0, 1'b0, 8'hA0 + 8'(i));
        check("s1_level", 32'(level), 32'd5);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 8'h00);
            check("s1_dout", 32'(data_out), 32'(exp1[i]));
            check("s1_active", 32'(pkt_active), 32'(act1[i]));
        end
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        check("s1_idle", 32'(data_out), 32'd0);

        // 2: fill, overflow attempt, drain
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 8'($urandom));
            if (i == 13) check("s2_afull14", 32'(almost_full), 32'd1);
        end
        check("s2_full", 32'(full), 32'd1);
        cyc(1'b1, 1'b0, 1'b0, 8'h5A);
        check("s2_drop", 32'(level), 32'd16);
`ifdef ROUTER_FIFO_PKT_ERR_EN
        check("s2_ovf", 32'(err_ovf), 32'd1);
`endif
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 1'b0, 8'h00);

        // 3: full with simultaneous write and read
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 1'b0, 8'($urandom));
        cyc(1'b1, 1'b1, 1'b0, 8'h77);
        check("s3_level", 32'(level), 32'd15);
        check("s3_full", 32'(full), 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 8'h78);
        check("s3_level2", 32'(level), 32'd15);

        // 4: hold level at 3 across pointer wrap
        for (int i = 0; i < 12; i++) cyc(1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 40; i++) cyc(1'b1, 1'b1, 1'b0, 8'($urandom));
        check("s4_level", 32'(level), 32'd3);

        // 5: soft reset mid-packet, then a fresh packet
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        cyc(1'b1, 1'b0, 1'b0, 8'h08);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 8'hC0 + 8'(i));
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        check("s5_active", 32'(pkt_active), 32'd1);
        cyc(1'b1, 1'b1, 1'b1, 8'h99, 1'b1, 1'b0);
        check("s5_empty", 32'(empty), 32'd1);
        check("s5_level", 32'(level), 32'd0);
        check("s5_act0", 32'(pkt_active), 32'd0);
        check("s5_dout0", 32'(data_out), 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 8'h04);
        cyc(1'b1, 1'b0, 1'b0, 8'hB1);
        cyc(1'b1, 1'b0, 1'b0, 8'hB2);
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        check("s5_hdr", 32'(data_out), 32'h04);
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        check("s5_b1", 32'(data_out), 32'hB1);
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        check("s5_b2", 32'(data_out), 32'hB2);
        check("s5_end", 32'(pkt_active), 32'd0);

        // 6: reads on an empty FIFO
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        check("s6_level", 32'(level), 32'd0);
        check("s6_dout", 32'(data_out), 32'd0);
`ifdef ROUTER_FIFO_PKT_ERR_EN
        check("s6_udf", 32'(err_udf), 32'd1);
`endif
        cyc(1'b1, 1'b1, 1'b0, 8'h3C);
        check("s6_wr", 32'(level), 32'd1);

        // Random traffic with headers, stray bytes and occasional flushes
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 50),
                1'($urandom_range(0, 9) == 0), 8'($urandom),
                1'($urandom_range(0, 59) == 0), 1'($urandom_range(0, 149) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
